// File: rtl/pbit_sample_controller_if.sv
//------------------------------------------------------------------------------
// Module  : pbit_sample_controller_if
// Brief   : Host-side config/result bus of the p-bit sample controller.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pbit_sample_controller_if #(
    parameter int N_PBITS = 3,
    parameter int STEP_W  = 16,
    parameter int BURN_W  = 8
);
    logic                            start;
    logic [2*N_PBITS-1:0]            cfg_clamp;
    logic [STEP_W-1:0]               cfg_steps;
    logic [BURN_W-1:0]               cfg_burn;
    logic                            busy;
    logic                            result_valid;
    logic                            result_ready;
    logic [N_PBITS*(STEP_W+1)-1:0]   sums;

    modport master (
        output start, cfg_clamp, cfg_steps, cfg_burn, result_ready,
        input  busy, result_valid, sums
    );

    modport slave (
        input  start, cfg_clamp, cfg_steps, cfg_burn, result_ready,
        output busy, result_valid, sums
    );
endinterface

`default_nettype wire

// File: rtl/pbit_sample_controller.sv
//------------------------------------------------------------------------------
// Module  : pbit_sample_controller
// Brief   : Runs one clamp/reset/burn-in/sample experiment per request and
//           accumulates a signed +/-1 sum for every p-bit.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pbit_sample_controller #(
    parameter int N_PBITS         = 3,
    parameter int STEP_W          = 16,
    parameter int BURN_W          = 8,
    parameter int GATE_RST_CYCLES = 2
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    pbit_sample_controller_if.slave   host,
    output logic                      gate_reset,
    output logic [2*N_PBITS-1:0]      clamp_out,
    input  wire logic [N_PBITS-1:0]   p_bits
);

    localparam int c_SUM_W  = STEP_W + 1;
    localparam int c_G_W    = (GATE_RST_CYCLES > 1) ? $clog2(GATE_RST_CYCLES) : 1;
    localparam int c_SB_W   = (STEP_W > BURN_W) ? STEP_W : BURN_W;
    localparam int c_CNT_W  = (c_SB_W > c_G_W) ? c_SB_W : c_G_W;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_GRST_LOAD = c_CNT_W'(GATE_RST_CYCLES - 1);
    localparam logic signed [c_SUM_W-1:0] c_PLUS  = c_SUM_W'(1);
    localparam logic signed [c_SUM_W-1:0] c_MINUS = -c_SUM_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRST   = 3'd1,
        S_BURN   = 3'd2,
        S_SAMPLE = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_CNT_W-1:0]          w_cnt_next;
    logic                        w_accept;
    logic                        w_sample;

    logic [2*N_PBITS-1:0]        r_clamp;
    logic [STEP_W-1:0]           r_steps;
    logic [BURN_W-1:0]           r_burn;
    logic signed [c_SUM_W-1:0]   r_sums [N_PBITS];
    logic [N_PBITS*c_SUM_W-1:0]  w_sums_flat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // r_cnt is a down-counter reloaded with (length - 1) on entry to each timed phase.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_accept          = 1'b0;
        w_sample          = 1'b0;
        gate_reset        = 1'b0;
        clamp_out         = r_clamp;
        host.busy         = 1'b1;
        host.result_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                gate_reset = 1'b1;
                clamp_out  = '0;
                host.busy  = 1'b0;
                if (host.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_GRST;
                    w_cnt_next   = c_GRST_LOAD;
                end
            end
            S_GRST: begin
                gate_reset = 1'b1;
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end else if (r_burn != '0) begin
                    w_state_next = S_BURN;
                    w_cnt_next   = c_CNT_W'(r_burn) - c_CNT_ONE;
                end else if (r_steps != '0) begin
                    w_state_next = S_SAMPLE;
                    w_cnt_next   = c_CNT_W'(r_steps) - c_CNT_ONE;
                end else begin
                    w_state_next = S_RESULT;
                end
            end
            S_BURN: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end else if (r_steps != '0) begin
                    w_state_next = S_SAMPLE;
                    w_cnt_next   = c_CNT_W'(r_steps) - c_CNT_ONE;
                end else begin
                    w_state_next = S_RESULT;
                end
            end
            S_SAMPLE: begin
                w_sample = 1'b1;
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end else begin
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                host.result_valid = 1'b1;
                if (host.result_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clamp <= '0;
            r_steps <= '0;
            r_burn  <= '0;
            for (int i = 0; i < N_PBITS; i++) begin
                r_sums[i] <= '0;
            end
        end else if (w_accept) begin
            r_clamp <= host.cfg_clamp;
            r_steps <= host.cfg_steps;
            r_burn  <= host.cfg_burn;
            for (int i = 0; i < N_PBITS; i++) begin
                r_sums[i] <= '0;
            end
        end else if (w_sample) begin
            for (int i = 0; i < N_PBITS; i++) begin
                r_sums[i] <= r_sums[i] + (p_bits[i] ? c_PLUS : c_MINUS);
            end
        end
    end

    always_comb begin
        w_sums_flat = '0;
        for (int i = 0; i < N_PBITS; i++) begin
            w_sums_flat[i*c_SUM_W +: c_SUM_W] = r_sums[i];
        end
    end

    assign host.sums = w_sums_flat;

endmodule

`default_nettype wire

// File: doc/pbit_sample_controller.md
# pbit_sample_controller

Hardware sequencer for a p-bit network such as the invertible AND gate. It runs one clamp experiment per request: it latches the clamp pattern, pulses the network reset, waits a burn-in period, then samples every p-bit output for a programmed number of cycles. Each p-bit gets a signed ±1 accumulator. The block replaces the bench-side averaging loop and sits between a host or config master and the p-bit array.

## Interface
- N_PBITS, 3: number of p-bits in the attached network.
- STEP_W, 16: width of the sample-count config; accumulators are STEP_W+1 bits signed.
- BURN_W, 8: width of the burn-in count config.
- GATE_RST_CYCLES, 2: cycles the network reset is held per experiment (≥1).

- clk  input  1  single clock.
- reset  input  1  synchronous, active-low.
- start  input  1  request an experiment; accepted only in IDLE.
- cfg_clamp  input  2*N_PBITS  per-bit {clamp_en, value} at [2i+1:2i]; latched on accept.
- cfg_steps  input  STEP_W  number of sampled cycles; latched on accept.
- cfg_burn  input  BURN_W  discarded cycles after network reset; latched on accept.
- gate_reset  output  1  active-high reset to the p-bit network.
- clamp_out  output  2*N_PBITS  clamp control to the network, same encoding as cfg_clamp.
- p_bits  input  N_PBITS  p-bit outputs from the network.
- busy  output  1  high in every state except IDLE.
- result_valid  output  1  sums are final; held until accepted.
- result_ready  input  1  consumer accepts the result.
- sums  output  N_PBITS*(STEP_W+1)  signed ±1 accumulators, bit i at slice i.

## Operation
- **States:** IDLE, GRST, BURN, SAMPLE, RESULT.
- **IDLE**
  - gate_reset=1, clamp_out=0, busy=0.
  - start=1 latches the config, clears all sums and goes to GRST.
- **GRST**
  - gate_reset=1 and clamp_out=latched clamp for GATE_RST_CYCLES cycles.
  - Then go to BURN if burn≠0, else SAMPLE if steps≠0, else RESULT.
- **BURN**
  - gate_reset=0. Count cfg_burn cycles; p_bits are ignored.
  - Then go to SAMPLE if steps≠0, else RESULT.
- **SAMPLE**
  - Each cycle, for every bit i: sum_i += p_bits[i] ? +1 : −1. This applies to clamped bits too.
  - After exactly cfg_steps samples, go to RESULT.
- **RESULT**
  - result_valid=1. Network keeps running (gate_reset=0, clamps held).
  - When result_valid & result_ready, go to IDLE next cycle.
- **Arithmetic:** sums range ±(2^STEP_W−1), so there is no overflow.
- **Value retention:** sums hold their value in IDLE until the next accepted start.
- **Reset:** reset=0 at any edge, including mid-experiment, forces IDLE.
  - Reset values: sums=0, result_valid=0, busy=0, gate_reset=1, clamp_out=0.
  - All latched config is discarded.
- **Start handling:** start while busy is ignored and is not queued. start and result_ready in the same RESULT cycle: the handshake completes and start is ignored.
- **Unchanged inputs:** cfg_* changes while busy have no effect.

## Timing
- start high at edge t in IDLE: busy=1 and gate_reset=1 from t+1.
- GRST spans t+1 … t+GATE_RST_CYCLES.
- BURN spans the next cfg_burn cycles.
- The first sample is p_bits at the first SAMPLE edge.
- result_valid rises the cycle after the last sample edge. With cfg_steps=S, cfg_burn=B, GRST=G, that is cycle t+1+G+B+S.
- result_valid=1 and ready=1 at edge r: IDLE and result_valid=0 at r+1; busy falls at r+1.
- Minimum experiment (B=0, S=0, ready held high): result_valid at t+1+G, IDLE at t+2+G; sums=0.
- clamp_out changes only on entering GRST (to latched value) and on entering IDLE (to 0).

## Test plan
- **Constant stub, basic run:** p_bits stub tied 3'b101, cfg_steps=1000, cfg_burn=10 → sums={−1000,+1000}: bit0=+1000, bit1=−1000, bit2=+1000. result_valid at t+1+2+10+1000; gate_reset low exactly 1010 cycles before result_valid.
- **AND gate, forward mode:** attach invertible AND, clamp a=1,b=1 (cfg_clamp=6'b001111), steps=1000 → sum_y>+600, sum_a=sum_b=+1000. Repeat with a=0,b=1 (6'b001110) → sum_y<−600.
- **Boundary counts:** cfg_steps=0, cfg_burn=0 → result_valid 3 cycles after start with all sums=0. cfg_steps=1, stub 3'b010 → sums={−1,+1,−1}.
- **Handshake:** hold result_ready=0 for 50 cycles → result_valid and sums stable. Pulse start during that window → ignored. Raise ready → IDLE next cycle, and a new start then clears sums.
- **Reset mid-run:** reset=0 at sample 500 of 1000 → next cycle IDLE, sums=0, gate_reset=1, clamp_out=0. A start after release runs the full 1000-sample experiment.
- **Alternating stub:** p_bits toggling 3'b000/3'b111 every cycle, steps=1001 starting on 3'b111 → all sums=+1.
